tone_audio_serializer: RTL and testbench

- Final audio stage, directly downstream of the beat/tone lookup that drives toneL/toneR frequencies in Hz.
- Turns two per-channel tone frequencies into signed 16-bit square-wave samples using a division-free phase accumulator.
- Serializes those samples onto the 4-wire DAC interface: master clock, left/right clock, serial clock and data.
- Takes the place of the stub instances in music_control, sitting between the tone lookup and the board audio pins.

---
 rtl/tone_audio_serializer_pkg.sv | 31 +++
 rtl/tone_audio_serializer_if.sv | 27 ++
 rtl/tone_audio_serializer_tone_gen.sv | 56 +++++
 rtl/tone_audio_serializer.sv | 72 +++++++
 tb/tb_tone_audio_serializer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/tone_audio_serializer_pkg.sv
// Shared audio constants: note table, clock rates,
// divider taps and the sample type.
package audio_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned SIL_HZ = 20_000;
  localparam logic [15:0] AMP_STEP = 16'h1000;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = 8;

  localparam int unsigned NOTE_C3 = 131;
  localparam int unsigned NOTE_D3 = 147;
  localparam int unsigned NOTE_E3 = 165;
  localparam int unsigned NOTE_F3 = 175;
  localparam int unsigned NOTE_G3 = 196;
  localparam int unsigned NOTE_A3 = 220;
  localparam int unsigned NOTE_B3 = 247;
  localparam int unsigned NOTE_C4 = 262;
  localparam int unsigned NOTE_D4 = 294;
  localparam int unsigned NOTE_E4 = 330;
  localparam int unsigned NOTE_F4 = 349;
  localparam int unsigned NOTE_G4 = 392;
  localparam int unsigned NOTE_A4 = 440;
  localparam int unsigned NOTE_B4 = 494;
  localparam int unsigned SILENCE_HZ = 50_000_000;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/tone_audio_serializer_if.sv
// Tone control inputs and DAC pin bundle.
// master = tone source, slave = serializer.
interface tone_audio_serializer_if;

  logic [31:0] tone_l;
  logic [31:0] tone_r;
  logic [2:0]  volume;
  logic        mute;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        frame_tick;

  modport master (
    output tone_l, tone_r, volume, mute,
    input  audio_mclk, audio_lrck, audio_sck,
    input  audio_sdin, frame_tick
  );

  modport slave (
    input  tone_l, tone_r, volume, mute,
    output audio_mclk, audio_lrck, audio_sck,
    output audio_sdin, frame_tick
  );

endinterface

// File: rtl/tone_audio_serializer_tone_gen.sv
// Division-free square-wave generator for one channel:
// phase accumulator wrapping at CLK_HZ/2.
module square_tone_gen #(
  parameter int unsigned CLK_HZ   = audio_pkg::CLK_HZ,
  parameter int unsigned SIL_HZ   = audio_pkg::SIL_HZ,
  parameter logic [15:0] AMP_STEP = audio_pkg::AMP_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       tone,
  input  logic [2:0]        volume,
  input  logic              mute,
  output audio_pkg::sample_t sample
);
  import audio_pkg::*;

  localparam logic [31:0] HALF = 32'(CLK_HZ / 2);
  localparam logic [31:0] SIL  = 32'(SIL_HZ);

  logic [31:0] acc;
  logic [31:0] sum;
  logic [15:0] amp;
  logic        phase;
  logic        silent;

  // silence detection, next accumulator value and amplitude
  always_comb begin
    silent = (tone == 32'd0) || (tone >= SIL);
    sum    = acc + tone;
    amp    = 16'({13'd0, volume} * AMP_STEP);
  end

  // accumulate; wrap at half the clock rate and flip phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      phase <= 1'b0;
    end else if (silent) begin
      acc   <= '0;
      phase <= 1'b0;
    end else if (sum >= HALF) begin
      acc   <= sum - HALF;
      phase <= ~phase;
    end else begin
      acc   <= sum;
    end
  end

  // signed square-wave sample from phase and volume
  always_comb begin
    sample = '0;
    if (!(mute || volume == 3'd0 || silent))
      sample = phase ? sample_t'(-amp) : sample_t'(amp);
  end

endmodule

// File: rtl/tone_audio_serializer.sv
// Two-channel square-wave synth serialized onto a
// left-justified 4-wire DAC link; all pins registered.
module tone_audio_serializer #(
  parameter int unsigned CLK_HZ   = audio_pkg::CLK_HZ,
  parameter int unsigned SIL_HZ   = audio_pkg::SIL_HZ,
  parameter logic [15:0] AMP_STEP = audio_pkg::AMP_STEP
) (
  input  logic clk,
  input  logic reset,
  tone_audio_serializer_if.slave bus
);
  import audio_pkg::*;

  logic [8:0] cnt;
  logic [8:0] cnt_nxt;
  logic       wrap;
  logic [3:0] bit_idx;
  sample_t    gen_l;
  sample_t    gen_r;
  sample_t    smp_l;
  sample_t    smp_r;
  sample_t    smp_l_nxt;
  sample_t    smp_r_nxt;

  square_tone_gen #(
    .CLK_HZ(CLK_HZ), .SIL_HZ(SIL_HZ), .AMP_STEP(AMP_STEP)
  ) u_gen_l (
    .clk(clk), .reset(reset), .tone(bus.tone_l),
    .volume(bus.volume), .mute(bus.mute), .sample(gen_l)
  );

  square_tone_gen #(
    .CLK_HZ(CLK_HZ), .SIL_HZ(SIL_HZ), .AMP_STEP(AMP_STEP)
  ) u_gen_r (
    .clk(clk), .reset(reset), .tone(bus.tone_r),
    .volume(bus.volume), .mute(bus.mute), .sample(gen_r)
  );

  // next count; samples swap in only at the frame boundary
  always_comb begin
    cnt_nxt   = cnt + 9'd1;
    wrap      = (cnt_nxt == 9'd0);
    bit_idx   = ~cnt_nxt[7:4];
    smp_l_nxt = wrap ? gen_l : smp_l;
    smp_r_nxt = wrap ? gen_r : smp_r;
  end

  // counter, sample latches and pins for the upcoming count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      smp_l          <= '0;
      smp_r          <= '0;
      bus.audio_mclk <= 1'b0;
      bus.audio_lrck <= 1'b0;
      bus.audio_sck  <= 1'b0;
      bus.audio_sdin <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      smp_l          <= smp_l_nxt;
      smp_r          <= smp_r_nxt;
      bus.audio_mclk <= cnt_nxt[MCLK_BIT];
      bus.audio_lrck <= cnt_nxt[LRCK_BIT];
      bus.audio_sck  <= cnt_nxt[SCK_BIT];
      bus.frame_tick <= wrap;
      bus.audio_sdin <= cnt_nxt[LRCK_BIT] ? smp_r_nxt[bit_idx]
                                          : smp_l_nxt[bit_idx];
    end
  end

endmodule

// File: tb/tb_tone_audio_serializer.sv
// Directed bench: decodes serial frames against
// hand-computed samples and pin timing.
module tb_tone_audio_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tone_audio_serializer_if au();

  tone_audio_serializer u_dut (
    .clk(clk), .reset(reset), .bus(au)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int bad_ratio = 0;
  int bad_tick = 0;
  int bad_edge = 0;
  int low_cnt = 0;
  logic [8:0] mc = '0;
  logic fresh = 1'b0;
  logic prev_sdin = 1'b0;
  logic [15:0] l, r;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mc = mc + 9'd1;
    fresh = 1'b0;
  endtask

  function automatic logic [4:0] outs();
    return {au.audio_mclk, au.audio_lrck, au.audio_sck,
            au.audio_sdin, au.frame_tick};
  endfunction

  task automatic do_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (outs() !== 5'd0) bad++;
    end
    check("rst_outs", bad, 0);
    reset = 1'b0;
    mc = '0;
    fresh = 1'b1;
    prev_sdin = 1'b0;
  endtask

  task automatic get_frame(input int mute_at,
                           output logic [15:0] fl,
                           output logic [15:0] fr);
    fl = '0;
    fr = '0;
    low_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (int'(mc) == mute_at) au.mute = 1'b1;
      if (au.audio_mclk !== mc[1] || au.audio_sck !== mc[3] ||
          au.audio_lrck !== mc[8]) bad_ratio++;
      if (au.frame_tick !== (mc == 9'd0 && !fresh)) bad_tick++;
      if (au.audio_sdin !== prev_sdin && mc[3:0] != 4'd0)
        bad_edge++;
      prev_sdin = au.audio_sdin;
      if (!au.audio_lrck) low_cnt++;
      if (mc[3:0] == 4'd8) begin
        if (mc[8]) fr = {fr[14:0], au.audio_sdin};
        else       fl = {fl[14:0], au.audio_sdin};
      end
      step();
    end
  endtask

  initial begin
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int k;
    au.tone_l = '0;
    au.tone_r = '0;
    au.volume = 3'd0;
    au.mute = 1'b0;

    // idle after reset, pin ratios over 8 frames
    do_reset();
    get_frame(-1, l, r);
    check("idle0_l", l, 0);
    check("idle0_r", r, 0);
    check("lrck_low", low_cnt, 256);
    for (int f = 1; f < 8; f++) get_frame(-1, l, r);
    check("idle7_r", r, 0);

    // 10 kHz left, volume 4: phase flips every 5000 clk
    au.tone_l = 32'd10_000;
    au.volume = 3'd4;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      get_frame(-1, l, r);
      if (f == 0) exp_l = 16'h0000;
      else if ((((512 * f) - 1) / 5000) % 2 == 1) exp_l = 16'hC000;
      else exp_l = 16'h4000;
      check($sformatf("tone_l_f%0d", f), l, exp_l);
      check($sformatf("tone_r_f%0d", f), r, 0);
    end

    // just below silence threshold toggles at edge 2501
    au.tone_l = '0;
    au.tone_r = 32'd19_999;
    do_reset();
    get_frame(-1, l, r);
    for (int f = 1; f < 7; f++) begin
      get_frame(-1, l, r);
      exp_r = (f < 5) ? 16'h4000 : 16'hC000;
      check($sformatf("sil19999_f%0d", f), r, exp_r);
    end
    au.tone_r = 32'd20_000;
    get_frame(-1, l, r);
    check("sil20000_keep", r, 16'hC000);
    check("sil20000_acc", u_dut.u_gen_r.acc, 0);
    get_frame(-1, l, r);
    check("sil20000_r", r, 0);
    au.tone_r = audio_pkg::SILENCE_HZ;
    get_frame(-1, l, r);
    check("sil50m_r", r, 0);
    check("sil50m_acc", u_dut.u_gen_r.acc, 0);

    // mute raised mid-frame only affects the next frame
    au.tone_l = 32'd10_000;
    au.tone_r = '0;
    au.volume = 3'd7;
    do_reset();
    get_frame(-1, l, r);
    get_frame(100, l, r);
    check("mute_cur_l", l, 16'h7000);
    check("mute_cur_r", r, 0);
    get_frame(-1, l, r);
    check("mute_nxt_l", l, 0);
    check("mute_nxt_r", r, 0);

    // asynchronous reset in the middle of a frame
    au.mute = 1'b0;
    au.tone_r = 32'd10_000;
    do_reset();
    get_frame(-1, l, r);
    get_frame(-1, l, r);
    check("pre_l", l, 16'h7000);
    check("pre_r", r, 16'h7000);
    k = 0;
    while (mc != 9'd300 && k < 600) begin
      step();
      k++;
    end
    check("reach300", mc, 300);
    check("pre_rst_lrck", au.audio_lrck, 1);
    reset = 1'b1;
    #1;
    check("rst_async", outs(), 0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    mc = '0;
    fresh = 1'b1;
    prev_sdin = 1'b0;
    get_frame(-1, l, r);
    check("post_rst_l", l, 0);
    check("post_rst_r", r, 0);
    check("post_rst_lrck_low", low_cnt, 256);

    check("clk_ratio", bad_ratio, 0);
    check("frame_tick", bad_tick, 0);
    check("sdin_edge", bad_edge, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
